// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer with a one-deep holding register, overrun and framing flags.
// Zero latency: the nibble is held from the edge that samples its 4th bit; a full holding register drops new nibbles.
module nibble_deser (
  input  logic _CLK,
  input  logic _CLR,
  input  logic _SER,
  input  logic _SEN,
  input  logic _SYNC,
  input  logic _RDY,
  output logic _QA,
  output logic _QB,
  output logic _QC,
  output logic _QD,
  output logic _VALID,
  output logic _BUSY,
  output logic _OVR,
  output logic _FERR
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e     state;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] stg_q, stg_d;
  // hold_q is {QA, QB, QC, QD}; stg_q[0] holds the first sampled bit.
  logic [3:0] hold_q, hold_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       done;

  always_ff @(posedge _CLK or negedge _CLR) begin
    if (!_CLR) begin
      cnt_q   <= 2'd0;
      stg_q   <= 3'b000;
      hold_q  <= 4'b0000;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state   = (cnt_q == 2'd0) ? IDLE : SHIFT;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;

    if (_SEN) begin
      if (_SYNC) begin
        if (state == SHIFT) ferr_d = 1'b1;
        stg_d = {2'b00, _SER};
        cnt_d = 2'd1;
      end else begin
        case (cnt_q)
          2'd0: begin stg_d[0] = _SER; cnt_d = 2'd1; end
          2'd1: begin stg_d[1] = _SER; cnt_d = 2'd2; end
          2'd2: begin stg_d[2] = _SER; cnt_d = 2'd3; end
          default: begin
            done  = 1'b1;
            stg_d = 3'b000;
            cnt_d = 2'd0;
          end
        endcase
      end
    end

    if (valid_q && _RDY) valid_d = 1'b0;

    // A transfer on the completing edge frees the holding register for the new nibble.
    if (done) begin
      if (!valid_q || _RDY) begin
        hold_d  = {_SER, stg_q[2], stg_q[1], stg_q[0]};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign _QA    = hold_q[3];
  assign _QB    = hold_q[2];
  assign _QC    = hold_q[1];
  assign _QD    = hold_q[0];
  assign _VALID = valid_q;
  assign _BUSY  = (state == SHIFT);
  assign _OVR   = ovr_q;
  assign _FERR  = ferr_q;

endmodule

// File: tb/tb_nibble_deser.sv
// Bench for nibble_deser: directed scenarios plus random traffic against a queue-based reference model.
module tb_nibble_deser;

  logic clk = 1'b0;
  logic clr_n, ser, sen, sync, rdy;
  logic qa, qb, qc, qd, valid, busy, ovr, ferr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bits received since the nibble started, held nibble as {QD,QC,QB,QA}.
  logic       m_bits[$];
  logic [3:0] m_q;
  logic       m_valid, m_ovr, m_ferr;

  nibble_deser dut (
    ._CLK(clk), ._CLR(clr_n), ._SER(ser), ._SEN(sen), ._SYNC(sync), ._RDY(rdy),
    ._QA(qa), ._QB(qb), ._QC(qc), ._QD(qd),
    ._VALID(valid), ._BUSY(busy), ._OVR(ovr), ._FERR(ferr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] obs();
    return {qd, qc, qb, qa, valid, busy, ovr, ferr};
  endfunction

  function automatic logic [7:0] expv();
    return {m_q, m_valid, logic'(m_bits.size() != 0), m_ovr, m_ferr};
  endfunction

  function automatic void model_clear();
    m_bits.delete();
    m_q     = 4'b0000;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endfunction

  function automatic void model_step(input logic s_en, s_sync, s_ser, s_rdy);
    logic       got;
    logic [3:0] nib;
    got = 1'b0;
    nib = 4'b0000;
    if (s_en) begin
      if (s_sync) begin
        if (m_bits.size() != 0) m_ferr = 1'b1;
        m_bits.delete();
      end
      m_bits.push_back(s_ser);
      if (m_bits.size() == 4) begin
        got = 1'b1;
        nib = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
        m_bits.delete();
      end
    end
    if (m_valid && s_rdy) m_valid = 1'b0;
    if (got) begin
      if (!m_valid) begin
        m_q     = nib;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  // Called at posedge+1; drives inputs, lets one edge pass, advances the model.
  task automatic cycle(input logic s_en, s_sync, s_ser, s_rdy);
    sen  = s_en;
    sync = s_sync;
    ser  = s_ser;
    rdy  = s_rdy;
    @(posedge clk);
    model_step(s_en, s_sync, s_ser, s_rdy);
    #1;
  endtask

  // Sends b[3] first; the resulting {QD,QC,QB,QA} equals b.
  task automatic send_nibble(input logic [3:0] b, input logic first_sync, input logic s_rdy);
    for (int i = 3; i >= 0; i--) cycle(1'b1, (i == 3) ? first_sync : 1'b0, b[i], s_rdy);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    sen = 1'b0; sync = 1'b0; ser = 1'b0; rdy = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    sen = 1'b0; sync = 1'b0; ser = 1'b0; rdy = 1'b0;
    model_clear();
    #3;
    n_vec++;
    if (obs() !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got %b required %b", obs(), 8'h00);
    end
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b required 1", busy); end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs() !== 8'b1011_1000) begin
      n_err++;
      $display("FAIL basic_capture: got %b required %b", obs(), 8'b1011_1000);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (valid !== 1'b0 || expv() !== obs()) begin
      n_err++;
      $display("FAIL basic_one_cycle: got %b required %b", obs(), expv());
    end
  endtask

  task automatic test_gapped();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL gapped_busy[%0d]: got %b required 1", g, busy);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs() !== 8'b1011_1000 || obs() !== expv()) begin
      n_err++;
      $display("FAIL gapped_capture: got %b required %b", obs(), 8'b1011_1000);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_nibble(4'b0110, 1'b1, 1'b0);
    n_vec++;
    if (obs() !== 8'b0110_1000) begin
      n_err++;
      $display("FAIL b2b_first: got %b required %b", obs(), 8'b0110_1000);
    end
    send_nibble(4'b1001, 1'b0, 1'b0);
    n_vec++;
    if (obs() !== 8'b0110_1010) begin
      n_err++;
      $display("FAIL b2b_overrun: got %b required %b", obs(), 8'b0110_1010);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (valid !== 1'b0 || ovr !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL b2b_drain: got %b required %b", obs(), expv());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_nibble(4'b1111, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs() !== 8'b1111_1100) begin
      n_err++;
      $display("FAIL simul_hold: got %b required %b", obs(), 8'b1111_1100);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs() !== 8'b0011_1000) begin
      n_err++;
      $display("FAIL simul_swap: got %b required %b", obs(), 8'b0011_1000);
    end
  endtask

  task automatic test_resync();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (ferr !== 1'b0) begin n_err++; $display("FAIL resync_pre: got %b required 0", ferr); end
    send_nibble(4'b0001, 1'b1, 1'b1);
    n_vec++;
    if (obs() !== 8'b0001_1001 || obs() !== expv()) begin
      n_err++;
      $display("FAIL resync: got %b required %b", obs(), 8'b0001_1001);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_nibble(4'b1111, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    clr_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: got %b required %b", obs(), 8'h00);
    end
    model_clear();
    sen = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    send_nibble(4'b1100, 1'b0, 1'b0);
    n_vec++;
    if (obs() !== 8'b1100_1000) begin
      n_err++;
      $display("FAIL reset_mid_capture: got %b required %b", obs(), 8'b1100_1000);
    end
  endtask

  task automatic test_random();
    logic r_en, r_sync, r_ser, r_rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r_en   = ($urandom_range(3) != 0);
      r_sync = ($urandom_range(7) == 0);
      r_ser  = 1'($urandom);
      r_rdy  = ($urandom_range(2) != 0);
      cycle(r_en, r_sync, r_ser, r_rdy);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random[%0d]: got %b required %b", c, obs(), expv());
      end
    end
  endtask

  initial begin
    clr_n = 1'b0;
    sen = 1'b0; sync = 1'b0; ser = 1'b0; rdy = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_simultaneous();
    test_resync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_deser.md
NIBBLE_DESER -- requirements
Module: nibble_deser

Interface
REQ-001 SHALL have port _CLK  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port _CLR  input  1  asynchronous active-low reset; forces all state to reset values immediately.
REQ-003 SHALL have port _SER  input  1  serial data bit, driven by QD of an upstream 4-bit right-shift register.
REQ-004 SHALL have port _SEN  input  1  shift enable; _SER is sampled only on edges where _SEN=1.
REQ-005 SHALL have port _SYNC  input  1  frame sync; with _SEN=1, marks the sampled bit as the first bit of a nibble.
REQ-006 SHALL have port _RDY  input  1  consumer ready for the held nibble.
REQ-007 SHALL have ports _QA, _QB, _QC, _QD  output  1 each  held parallel nibble.
REQ-008 SHALL have port _VALID  output  1  held nibble is present and not yet consumed.
REQ-009 SHALL have port _BUSY  output  1  partial nibble in progress (bit count 1..3).
REQ-010 SHALL have port _OVR  output  1  sticky overrun flag.
REQ-011 SHALL have port _FERR  output  1  sticky framing-error flag.
REQ-012 SHALL use one clock, with reset asynchronous and active-low on _CLR.

Function
REQ-013 SHALL keep a 2-bit bit counter CNT (0..3) and a 3-bit staging register. The FSM state is IDLE when CNT=0 and SHIFT when CNT=1..3.
REQ-014 SHALL map bit order to upstream shift-out order: 1st sampled bit -> _QD, 2nd -> _QC, 3rd -> _QB, 4th -> _QA.
REQ-015 SHALL, on an edge with _SEN=1 and _SYNC=0, store _SER at position CNT and increment CNT; a 4th bit completes the nibble and wraps CNT to 0.
REQ-016 SHALL, on an edge with _SEN=1 and _SYNC=1, discard any partial bits, store _SER as the 1st bit and set CNT=1.
REQ-017 SHALL, in the case of REQ-016, set _FERR if CNT was nonzero before that edge.
REQ-018 SHALL ignore _SYNC when _SEN=0. When _SEN=0, CNT and staging hold.
REQ-019 SHALL, on nibble completion with the holding register free, load _QA.._QD and set _VALID=1 on the same rising edge that samples the 4th bit (zero extra latency).
REQ-020 SHALL define the holding register as free when _VALID=0, or when _VALID=1 and _RDY=1 on that edge.
REQ-021 SHALL count a transfer on each edge where _VALID=1 and _RDY=1. After a transfer _VALID=0, unless a new nibble completes on the same edge, in which case the new nibble loads and _VALID stays 1.
REQ-022 SHALL, on nibble completion when _VALID=1 and _RDY=0, drop the new nibble, retain the held nibble unchanged and set _OVR.
REQ-023 SHALL hold _QA.._QD stable while _VALID=1 and no transfer occurs.
REQ-024 SHALL keep _OVR and _FERR set until _CLR is asserted; no other event clears them.
REQ-025 SHALL drive _BUSY=1 exactly when CNT is nonzero. All outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-026 SHALL, while _CLR=0, force CNT=0, staging=000, _QA.._QD=0, _VALID=0, _BUSY=0, _OVR=0 and _FERR=0, independent of _CLK.
REQ-027 SHALL, if _CLR is asserted mid-nibble or with _VALID=1, lose the partial bits and the held nibble. The first _SEN=1 edge after _CLR rises SHALL be treated as bit 1.

Verification
REQ-028 SHALL test basic capture: _RDY=1; bits 1,0,1,1 on four consecutive _SEN edges, _SYNC=1 on the first -> after the 4th edge QD,QC,QB,QA=1,0,1,1, _VALID=1 for one cycle, _BUSY=0.
REQ-029 SHALL test gapped input: same nibble with _SEN=0 for 3 cycles between bits 2 and 3 -> identical result, and _BUSY=1 throughout the gap.
REQ-030 SHALL test back-to-back capture: _RDY=0, nibble 0110 completes (_VALID=1); second nibble 1001 completes with _RDY=0 -> outputs stay 0110 and _OVR=1. Then _RDY=1 for one edge -> _VALID=0 and _OVR stays 1.
REQ-031 SHALL test simultaneous transfer and completion: _VALID=1 holding 1111, _RDY=1 on the edge completing 0011 -> outputs become 0011, _VALID stays 1, _OVR=0.
REQ-032 SHALL test resync: two bits 1,1 then _SYNC=1 with bits 0,0,0,1 -> _FERR=1 and output 0001.
REQ-033 SHALL test reset mid-nibble: assert _CLR asynchronously between edges after 2 bits -> all outputs 0 at once; next 4 bits 1100 with no _SYNC -> output 1100.
